rvs_station: RTL and testbench
==============================

Name: rvs_station

Overview:
- Reservation station. Sits on the rvs side of the decoder-to-station dispatch interface (dec2rvs) and drives the station-to-execution-unit issue interface (rvs2exu).
- Holds up to DEPTH dispatched ops and snoops the CDB (cdb_itf slv) to wake pending operands.
- Issues ready ops to one execution unit.
- Owns a fixed block of destination tags. A tag is reused only after its result has been broadcast on the CDB.

Parameters:
- TAG_W, 4, width of all tags.
- OPC_W, 4, opcode width.
- DEPTH, 4, number of entries (power of two, at least 2).
- RVS_ID, 1, station index. Tags owned are RVS_ID*DEPTH + idx. Tag value 0 is never owned.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dec_req  in  1  dispatch request
- dec_rdy  out  1  a free entry exists
- dec_tag  out  TAG_W  destination tag the next accepted dispatch will receive
- dec_opc  in  OPC_W  opcode
- dec_src1_vld / dec_src2_vld  in  1 each  operand value present
- dec_src1_tag / dec_src2_tag  in  TAG_W each  producer tag when the operand is not present
- dec_src1_wdata / dec_src2_wdata  in  32 each  operand value when present
- dec_offset  in  12  immediate/offset
- exu_req  out  1  issue request
- exu_rdy  in  1  execution unit accepts
- exu_tag  out  TAG_W  tag of the issued op
- exu_opc  out  OPC_W  opcode of the issued op
- exu_src1 / exu_src2  out  32 each  operands of the issued op
- exu_offset  out  12  offset of the issued op
- cdb_wr  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_wdata  in  32  broadcast value

Behaviour:
- Per-entry state: EMPTY, WAIT (at least one operand pending), READY, ISSUED.
- Reset: all entries EMPTY and all entry fields cleared.
  - Outputs: dec_rdy=1, dec_tag=RVS_ID*DEPTH, exu_req=0, all exu_* data 0.
  - Assertion of rst_n mid-operation discards every entry immediately.
- Dispatch:
  - dec_rdy = any entry EMPTY.
  - dec_tag = RVS_ID*DEPTH + lowest-index EMPTY entry. Combinational from state; stable while no dispatch occurs.
  - Accept on dec_req && dec_rdy. The chosen entry captures opc, offset and operands.
  - Entry goes to READY if both operands are valid after bypass, else WAIT.
  - dec_req while dec_rdy=0 is ignored.
- Dispatch bypass: if cdb_wr and cdb_tag equals an incoming dec_srcN_tag with dec_srcN_vld=0, capture cdb_wdata as valid in the same cycle.
- CDB snoop, each cycle cdb_wr=1:
  - Every WAIT entry whose pending srcN_tag == cdb_tag latches cdb_wdata and marks srcN valid.
  - A WAIT entry whose operands are all valid afterwards becomes READY at the next edge.
  - Tag 0 broadcasts are treated normally. They never match an owned tag.
- Issue:
  - exu_req = any entry READY. The selected entry is the lowest-index READY entry.
  - exu_* are driven combinationally from the selected entry.
  - Transfer on exu_req && exu_rdy: the entry goes to ISSUED.
  - With exu_rdy=0, the selected entry holds and its outputs stay constant.
  - An entry that became READY this cycle is eligible from the next cycle (latency: dispatch with both operands valid → exu_req one cycle later).
- Free: in the cycle cdb_wr=1 and cdb_tag equals the tag of an ISSUED entry, that entry goes to EMPTY. Its tag is visible on dec_tag from the next cycle, never the same cycle.
- Simultaneous events, all in one cycle with no interference:
  - dispatch into entry i;
  - issue of entry j;
  - CDB wake of entries k;
  - free of entry m.
  - Indices i, j and m are distinct by construction, since they are selected from different states.
- Full: with all entries non-EMPTY, dec_rdy=0. dec_rdy returns 1 the cycle after the first free.
- Operand registers are 32 bits, copied verbatim. No arithmetic is performed.

Decomposition:
- Shared package (rvs_pkg) holds:
  - the entry-state enum (EMPTY, WAIT, READY, ISSUED);
  - the entry struct (state, opc, offset, per-source vld/tag/data);
  - function tag_of(idx).
- One natural sub-module, prio_enc_lsb: a parameterised lowest-set-bit priority encoder producing valid and index. It is instantiated twice, once for free-entry select and once for ready-entry select.

Test Plan:
- Dispatch opc=3, src1_vld=1 src1=0x10, src2_vld=1 src2=0x20, offset=0x7FF, exu_rdy=1 → dec_tag=4 at dispatch. Next cycle exu_req=1 with tag=4, src1=0x10, src2=0x20, offset=0x7FF. Entry stays ISSUED until cdb_wr with tag=4, after which dec_tag=4 is available again.
- Dispatch src1 pending on tag=9, then cdb_wr tag=9 wdata=0xDEADBEEF two cycles later → exu_req rises the cycle after the broadcast with exu_src1=0xDEADBEEF. A broadcast with tag=8 causes no wake.
- Same-cycle bypass: dispatch with src2 pending on tag=12 while cdb_wr tag=12 wdata=0x55 → entry enters READY. exu_req=1 next cycle with src2=0x55.
- Dispatch 4 ops with exu_rdy=0 → dec_rdy=0 after the 4th. An extra dec_req is ignored (no state change). exu_req stays 1 with tag=4 held constant. Raise exu_rdy for one cycle → tag=5 is presented next.
- Simultaneous case: dispatch into entry 2, issue of entry 0, CDB free of ISSUED entry 1, and CDB wake of entry 3, all in one cycle → final states READY/ISSUED pattern, checked entry by entry. dec_tag reflects entry 1 (tag 5) only the following cycle.
- Assert rst_n low mid-operation with 3 entries occupied → asynchronously exu_req=0, dec_rdy=1, dec_tag=4. A CDB broadcast after release affects nothing.

Source files
------------

// File: rtl/rvs_pkg.sv
// Shared types for the reservation station: entry state, entry record and tag mapping.
package rvs_pkg;

    localparam int RVS_TAG_W      = 4;
    localparam int RVS_OPC_W      = 4;
    localparam int RVS_DEPTH      = 4;
    localparam int RVS_STATION_ID = 1;
    localparam int RVS_OFF_W      = 12;
    localparam int RVS_DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_ISSUED = 2'd3
    } ent_state_e;

    // ST_EMPTY must stay the all-zero encoding so that clearing an entry empties it.
    typedef struct packed {
        ent_state_e              state;
        logic [RVS_OPC_W-1:0]    opc;
        logic [RVS_OFF_W-1:0]    offset;
        logic                    s1_vld;
        logic [RVS_TAG_W-1:0]    s1_tag;
        logic [RVS_DATA_W-1:0]   s1_data;
        logic                    s2_vld;
        logic [RVS_TAG_W-1:0]    s2_tag;
        logic [RVS_DATA_W-1:0]   s2_data;
    } ent_t;

    // Destination tag owned by entry idx of station rvs_id.
    function automatic logic [RVS_TAG_W-1:0] tag_of(input int unsigned idx,
                                                    input int unsigned rvs_id = RVS_STATION_ID,
                                                    input int unsigned depth  = RVS_DEPTH);
        return RVS_TAG_W'(rvs_id * depth + idx);
    endfunction

endpackage

// File: rtl/rvs_station_prio.sv
// Lowest-set-bit priority encoder: vld if any request, idx of the lowest one.
module prio_enc_lsb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest requesting index wins.
    always_comb begin
        vld = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/rvs_station.sv
// Reservation station: accepts dispatched ops, wakes operands from the CDB,
// issues ready ops to one execution unit and recycles its tags on result broadcast.
module rvs_station
    import rvs_pkg::*;
#(
    parameter int TAG_W  = RVS_TAG_W,
    parameter int OPC_W  = RVS_OPC_W,
    parameter int DEPTH  = RVS_DEPTH,
    parameter int RVS_ID = RVS_STATION_ID
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_req,
    output logic             dec_rdy,
    output logic [TAG_W-1:0] dec_tag,
    input  logic [OPC_W-1:0] dec_opc,
    input  logic             dec_src1_vld,
    input  logic             dec_src2_vld,
    input  logic [TAG_W-1:0] dec_src1_tag,
    input  logic [TAG_W-1:0] dec_src2_tag,
    input  logic [31:0]      dec_src1_wdata,
    input  logic [31:0]      dec_src2_wdata,
    input  logic [11:0]      dec_offset,
    output logic             exu_req,
    input  logic             exu_rdy,
    output logic [TAG_W-1:0] exu_tag,
    output logic [OPC_W-1:0] exu_opc,
    output logic [31:0]      exu_src1,
    output logic [31:0]      exu_src2,
    output logic [11:0]      exu_offset,
    input  logic             cdb_wr,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_wdata
);

    localparam int IDX_W = $clog2(DEPTH);

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    logic [TAG_W-1:0] own_tag [DEPTH];
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] rdy_vec;
    logic             free_vld;
    logic             rdy_vld;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] rdy_idx;
    logic             do_disp;
    logic             do_issue;
    logic             in_s1_vld;
    logic             in_s2_vld;
    logic [31:0]      in_s1_data;
    logic [31:0]      in_s2_data;

    // Per-entry tags and the empty / ready masks feeding the two selectors.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            own_tag[i]  = tag_of(i, RVS_ID, DEPTH);
            free_vec[i] = (ent_q[i].state == ST_EMPTY);
            rdy_vec[i]  = (ent_q[i].state == ST_READY);
        end
    end

    prio_enc_lsb #(.N(DEPTH), .IDX_W(IDX_W)) u_free_sel (
        .req (free_vec),
        .vld (free_vld),
        .idx (free_idx)
    );

    prio_enc_lsb #(.N(DEPTH), .IDX_W(IDX_W)) u_rdy_sel (
        .req (rdy_vec),
        .vld (rdy_vld),
        .idx (rdy_idx)
    );

    assign dec_rdy  = free_vld;
    assign dec_tag  = own_tag[free_idx];
    assign exu_req  = rdy_vld;
    assign do_disp  = dec_req && free_vld;
    assign do_issue = rdy_vld && exu_rdy;

    // Issue port shows the selected READY entry, zeros when nothing is ready.
    always_comb begin
        exu_tag    = '0;
        exu_opc    = '0;
        exu_src1   = '0;
        exu_src2   = '0;
        exu_offset = '0;
        if (rdy_vld) begin
            exu_tag    = own_tag[rdy_idx];
            exu_opc    = ent_q[rdy_idx].opc;
            exu_src1   = ent_q[rdy_idx].s1_data;
            exu_src2   = ent_q[rdy_idx].s2_data;
            exu_offset = ent_q[rdy_idx].offset;
        end
    end

    // Incoming operands with same-cycle CDB bypass for pending sources.
    always_comb begin
        in_s1_vld  = dec_src1_vld || (cdb_wr && (cdb_tag == dec_src1_tag));
        in_s2_vld  = dec_src2_vld || (cdb_wr && (cdb_tag == dec_src2_tag));
        in_s1_data = dec_src1_vld ? dec_src1_wdata : (in_s1_vld ? cdb_wdata : 32'd0);
        in_s2_data = dec_src2_vld ? dec_src2_wdata : (in_s2_vld ? cdb_wdata : 32'd0);
    end

    // Per-entry next state; dispatch, issue, wake and free act on disjoint states.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            case (ent_q[i].state)
                ST_EMPTY: begin
                    if (do_disp && (free_idx == IDX_W'(i))) begin
                        ent_d[i].opc     = dec_opc;
                        ent_d[i].offset  = dec_offset;
                        ent_d[i].s1_vld  = in_s1_vld;
                        ent_d[i].s1_tag  = dec_src1_tag;
                        ent_d[i].s1_data = in_s1_data;
                        ent_d[i].s2_vld  = in_s2_vld;
                        ent_d[i].s2_tag  = dec_src2_tag;
                        ent_d[i].s2_data = in_s2_data;
                        ent_d[i].state   = (in_s1_vld && in_s2_vld) ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cdb_wr && !ent_q[i].s1_vld && (ent_q[i].s1_tag == cdb_tag)) begin
                        ent_d[i].s1_vld  = 1'b1;
                        ent_d[i].s1_data = cdb_wdata;
                    end
                    if (cdb_wr && !ent_q[i].s2_vld && (ent_q[i].s2_tag == cdb_tag)) begin
                        ent_d[i].s2_vld  = 1'b1;
                        ent_d[i].s2_data = cdb_wdata;
                    end
                    if (ent_d[i].s1_vld && ent_d[i].s2_vld) ent_d[i].state = ST_READY;
                end
                ST_READY: begin
                    if (do_issue && (rdy_idx == IDX_W'(i))) ent_d[i].state = ST_ISSUED;
                end
                ST_ISSUED: begin
                    if (cdb_wr && (cdb_tag == own_tag[i])) ent_d[i] = '0;
                end
                default: ent_d[i] = '0;
            endcase
        end
    end

    // Entry registers; reset discards every entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

endmodule

// File: tb/tb_rvs_station.sv
// Directed bench for rvs_station (RVS_ID=1, DEPTH=4: owned tags 4..7).
module tb_rvs_station;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_req;
    logic        dec_rdy;
    logic [3:0]  dec_tag;
    logic [3:0]  dec_opc;
    logic        dec_src1_vld, dec_src2_vld;
    logic [3:0]  dec_src1_tag, dec_src2_tag;
    logic [31:0] dec_src1_wdata, dec_src2_wdata;
    logic [11:0] dec_offset;
    logic        exu_req;
    logic        exu_rdy;
    logic [3:0]  exu_tag;
    logic [3:0]  exu_opc;
    logic [31:0] exu_src1, exu_src2;
    logic [11:0] exu_offset;
    logic        cdb_wr;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_wdata;

    int n_chk = 0;
    int n_err = 0;

    rvs_station dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dec_req        (dec_req),
        .dec_rdy        (dec_rdy),
        .dec_tag        (dec_tag),
        .dec_opc        (dec_opc),
        .dec_src1_vld   (dec_src1_vld),
        .dec_src2_vld   (dec_src2_vld),
        .dec_src1_tag   (dec_src1_tag),
        .dec_src2_tag   (dec_src2_tag),
        .dec_src1_wdata (dec_src1_wdata),
        .dec_src2_wdata (dec_src2_wdata),
        .dec_offset     (dec_offset),
        .exu_req        (exu_req),
        .exu_rdy        (exu_rdy),
        .exu_tag        (exu_tag),
        .exu_opc        (exu_opc),
        .exu_src1       (exu_src1),
        .exu_src2       (exu_src2),
        .exu_offset     (exu_offset),
        .cdb_wr         (cdb_wr),
        .cdb_tag        (cdb_tag),
        .cdb_wdata      (cdb_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        dec_req   = 1'b0;
        cdb_wr    = 1'b0;
        cdb_tag   = '0;
        cdb_wdata = '0;
    endtask

    task automatic disp(input logic [3:0] opc,
                        input logic v1, input logic [3:0] t1, input logic [31:0] d1,
                        input logic v2, input logic [3:0] t2, input logic [31:0] d2,
                        input logic [11:0] off);
        dec_req        = 1'b1;
        dec_opc        = opc;
        dec_src1_vld   = v1;
        dec_src1_tag   = t1;
        dec_src1_wdata = d1;
        dec_src2_vld   = v2;
        dec_src2_tag   = t2;
        dec_src2_wdata = d2;
        dec_offset     = off;
    endtask

    task automatic bcast(input logic [3:0] t, input logic [31:0] d);
        cdb_wr    = 1'b1;
        cdb_tag   = t;
        cdb_wdata = d;
    endtask

    initial begin
        rst_n   = 1'b0;
        exu_rdy = 1'b0;
        idle();
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        dec_req = 1'b0;
        #2;
        check("rst_dec_rdy", dec_rdy, 1);
        check("rst_dec_tag", dec_tag, 4);
        check("rst_exu_req", exu_req, 0);
        check("rst_exu_src1", exu_src1, 0);
        check("rst_exu_tag", exu_tag, 0);
        #2;
        rst_n = 1'b1;

        // Basic dispatch, issue and free.
        exu_rdy = 1'b1;
        disp(3, 1, 0, 32'h10, 1, 0, 32'h20, 12'h7FF);
        check("t1_dec_tag", dec_tag, 4);
        check("t1_req_before", exu_req, 0);
        tick(); idle();
        check("t1_exu_req", exu_req, 1);
        check("t1_exu_tag", exu_tag, 4);
        check("t1_exu_opc", exu_opc, 3);
        check("t1_exu_src1", exu_src1, 32'h10);
        check("t1_exu_src2", exu_src2, 32'h20);
        check("t1_exu_offset", exu_offset, 12'h7FF);
        check("t1_dec_tag_next", dec_tag, 5);
        tick();
        check("t1_issued_req", exu_req, 0);
        check("t1_issued_tag_held", dec_tag, 5);
        bcast(4, 32'h99);
        check("t1_free_same_cycle", dec_tag, 5);
        tick(); idle();
        check("t1_freed", dec_tag, 4);

        // Wake from CDB, non-matching tag ignored.
        disp(1, 0, 9, 0, 1, 0, 32'h2, 0);
        tick(); idle();
        check("t2_wait_req", exu_req, 0);
        bcast(8, 32'h1234);
        tick(); idle();
        check("t2_no_wake", exu_req, 0);
        bcast(9, 32'hDEADBEEF);
        check("t2_wake_same_cycle", exu_req, 0);
        tick(); idle();
        check("t2_wake_req", exu_req, 1);
        check("t2_wake_src1", exu_src1, 32'hDEADBEEF);
        check("t2_wake_src2", exu_src2, 32'h2);
        tick();
        bcast(4, 0);
        tick(); idle();
        check("t2_freed", dec_tag, 4);

        // Same-cycle bypass on dispatch.
        disp(2, 1, 0, 32'h7, 0, 12, 0, 12'h3);
        bcast(12, 32'h55);
        tick(); idle();
        check("t3_bypass_req", exu_req, 1);
        check("t3_bypass_src2", exu_src2, 32'h55);
        check("t3_bypass_src1", exu_src1, 32'h7);
        tick();
        bcast(4, 0);
        tick(); idle();
        check("t3_freed", dec_tag, 4);

        // Fill the station with the execution unit stalled.
        exu_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(4'(k + 1), 1, 0, 32'h100 + k, 1, 0, 32'h200 + k, 12'(k));
            check("t4_fill_tag", dec_tag, 4 + k);
            tick();
        end
        idle();
        check("t4_full_rdy", dec_rdy, 0);
        check("t4_full_req", exu_req, 1);
        check("t4_full_tag", exu_tag, 4);
        check("t4_full_src1", exu_src1, 32'h100);
        disp(15, 1, 0, 32'hBAD, 1, 0, 32'hBAD, 0);
        tick(); idle();
        check("t4_extra_rdy", dec_rdy, 0);
        check("t4_extra_tag", exu_tag, 4);
        check("t4_extra_src1", exu_src1, 32'h100);
        check("t4_extra_opc", exu_opc, 1);
        tick();
        check("t4_hold_tag", exu_tag, 4);
        exu_rdy = 1'b1;
        tick();
        exu_rdy = 1'b0;
        check("t4_next_tag", exu_tag, 5);
        check("t4_next_src1", exu_src1, 32'h101);
        bcast(4, 0);
        check("t4_free_same_rdy", dec_rdy, 0);
        tick(); idle();
        check("t4_free_rdy", dec_rdy, 1);
        check("t4_free_tag", dec_tag, 4);

        // Build: e0 WAIT, e1 ISSUED, e2 EMPTY, e3 WAIT on tag 5.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        exu_rdy = 1'b0;
        disp(1, 0, 14, 0, 1, 0, 32'hA2, 0);
        tick();
        disp(2, 1, 0, 32'hB1, 1, 0, 32'hB2, 0);
        tick();
        disp(3, 1, 0, 32'hC1, 1, 0, 32'hC2, 0);
        tick();
        exu_rdy = 1'b1;
        disp(4, 1, 0, 32'hD1, 0, 5, 0, 0);
        check("t5_d_exu_tag", exu_tag, 5);
        check("t5_d_dec_tag", dec_tag, 7);
        tick(); idle();
        check("t5_e_exu_tag", exu_tag, 6);
        tick();
        exu_rdy = 1'b0;
        bcast(6, 0);
        tick(); idle();
        check("t5_f_dec_tag", dec_tag, 6);
        check("t5_f_exu_req", exu_req, 0);
        bcast(14, 32'hAA);
        tick(); idle();
        check("t5_g_exu_req", exu_req, 1);
        check("t5_g_exu_tag", exu_tag, 4);
        check("t5_g_src1", exu_src1, 32'hAA);

        // Dispatch e2, issue e0, free e1 and wake e3 in one cycle.
        exu_rdy = 1'b1;
        disp(5, 1, 0, 32'hE1, 1, 0, 32'hE2, 0);
        bcast(5, 32'hC0FFEE);
        check("sim_dec_tag_same", dec_tag, 6);
        tick(); idle();
        check("sim_dec_tag_next", dec_tag, 5);
        check("sim_dec_rdy", dec_rdy, 1);
        check("sim_e2_req", exu_req, 1);
        check("sim_e2_tag", exu_tag, 6);
        check("sim_e2_src1", exu_src1, 32'hE1);
        tick();
        exu_rdy = 1'b0;
        check("sim_e3_tag", exu_tag, 7);
        check("sim_e3_src1", exu_src1, 32'hD1);
        check("sim_e3_src2", exu_src2, 32'hC0FFEE);
        bcast(4, 0);
        tick(); idle();
        check("sim_e0_freed", dec_tag, 4);
        check("sim_e3_held", exu_tag, 7);

        // Asynchronous reset with three entries occupied.
        disp(6, 1, 0, 32'h1, 1, 0, 32'h2, 0);
        tick(); idle();
        check("t6_pre_dec_tag", dec_tag, 5);
        check("t6_pre_exu_tag", exu_tag, 4);
        rst_n = 1'b0;
        #1;
        check("t6_rst_exu_req", exu_req, 0);
        check("t6_rst_dec_rdy", dec_rdy, 1);
        check("t6_rst_dec_tag", dec_tag, 4);
        check("t6_rst_src1", exu_src1, 0);
        #2;
        rst_n = 1'b1;
        bcast(7, 32'h77);
        tick(); idle();
        check("t6_post_exu_req", exu_req, 0);
        check("t6_post_dec_tag", dec_tag, 4);
        check("t6_post_dec_rdy", dec_rdy, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
